// File: rtl/pkt_dma_writer.sv
// pkt_dma_writer: Avalon-MM write master. It copies one captured packet from an
// Avalon-ST word stream into HPS SDRAM through the F2SDRAM port.
// Optional stall watchdog: define PKT_DMA_TIMEOUT_EN.
// Ports:
//   clk, reset (async, active-low)
//   start, pkt_addr, pkt_len       : register-bank control and transfer setup
//   st_*                           : Avalon-ST sink (st_ready is registered)
//   avm_*                          : Avalon-MM write master (all registered)
//   state, bytes_written           : progress status (00 idle/01 busy/10 done/11 error)
module pkt_dma_writer #(
  parameter int unsigned N              = 32,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] pkt_addr,
  input  logic [N-1:0] pkt_len,
  input  logic [N-1:0] st_data,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic         st_sop,
  input  logic         st_eop,
  input  logic [1:0]   st_empty,
  output logic [N-1:0] avm_address,
  output logic         avm_write,
  output logic [N-1:0] avm_writedata,
  output logic [3:0]   avm_byteenable,
  input  logic         avm_waitrequest,
  output logic [1:0]   state,
  output logic [N-1:0] bytes_written
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SOP, S_WRITE, S_DRAIN, S_DONE, S_ERROR
  } state_t;

  typedef struct packed {
    logic [3:0]   be;
    logic [N-1:0] data;
  } word_t;

  state_t             state_q, state_n;
  logic [N-1:0]       addr_q, addr_n, bytes_q, bytes_n;
  logic [N-1:0]       words_q, words_n, len_words_q, len_words_n;
  logic [3:0]         len_mask_q, len_mask_n;
  logic               trunc_q, trunc_n, eop_q, eop_n;
  logic               write_q, write_n, ready_q, ready_n;
  logic [1:0]         status_q, status_n;
  word_t              head_q, head_n;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_n, rd_ptr_q, rd_ptr_n;
  logic [CNT_W-1:0]   count_q, count_n, remain;
  word_t              mem [FIFO_DEPTH];
  word_t              push_word;
  logic               accept, push, pop, lim_hit;
  logic [3:0]         beat_mask;

`ifdef PKT_DMA_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]    to_cnt_q, to_cnt_n;
`else
  logic [N-1:0]       unused_timeout;
  assign unused_timeout = N'(TIMEOUT_CYCLES);
`endif

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // Next-state, FIFO bookkeeping and next values of every registered output
  always_comb begin
    state_n     = state_q;
    addr_n      = addr_q;
    bytes_n     = bytes_q;
    words_n     = words_q;
    len_words_n = len_words_q;
    len_mask_n  = len_mask_q;
    trunc_n     = trunc_q;
    eop_n       = eop_q;
    head_n      = head_q;
    push        = 1'b0;
    pop         = write_q && !avm_waitrequest;
    accept      = st_valid && ready_q;
`ifdef PKT_DMA_TIMEOUT_EN
    to_cnt_n    = '0;
`endif

    // Byte lanes for the incoming beat: eop trims from the MSB end, the final
    // word allowed by pkt_len is trimmed to the residual byte count.
    lim_hit   = (words_q + N'(1)) == len_words_q;
    beat_mask = st_eop ? (4'hF >> st_empty) : 4'hF;
    if (lim_hit) beat_mask = beat_mask & len_mask_q;
    push_word = '{be: beat_mask, data: st_data};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_n      = pkt_addr;
          bytes_n     = '0;
          words_n     = '0;
          trunc_n     = 1'b0;
          eop_n       = 1'b0;
          len_words_n = {2'b00, pkt_len[N-1:2]} + N'(|pkt_len[1:0]);
          case (pkt_len[1:0])
            2'd1:    len_mask_n = 4'h1;
            2'd2:    len_mask_n = 4'h3;
            2'd3:    len_mask_n = 4'h7;
            default: len_mask_n = 4'hF;
          endcase
          state_n = (pkt_len == '0 || pkt_addr[1:0] != 2'b00) ? S_ERROR : S_WAIT_SOP;
        end
      end
      S_WAIT_SOP: push = accept && st_sop;
      S_WRITE: begin
        push = accept;
        if (eop_q && count_q == '0) state_n = trunc_q ? S_ERROR : S_DONE;
      end
      S_DRAIN: begin
        if (accept && st_eop) eop_n = 1'b1;
        if (eop_q && count_q == '0) state_n = trunc_q ? S_ERROR : S_DONE;
      end
      S_DONE, S_ERROR: if (!start) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // A pushed beat either closes the packet (eop) or, at the length limit,
    // sends the rest of the packet to the drain.
    if (push) begin
      words_n = words_q + N'(1);
      if (st_eop) begin
        eop_n   = 1'b1;
        state_n = S_WRITE;
      end else if (lim_hit) begin
        trunc_n = 1'b1;
        state_n = S_DRAIN;
      end else begin
        state_n = S_WRITE;
      end
    end

    count_n  = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_n = wr_ptr_q + PTR_W'(push);
    rd_ptr_n = rd_ptr_q + PTR_W'(pop);
    remain   = count_q - CNT_W'(pop);
    if (pop) begin
      addr_n  = addr_q + N'(4);
      bytes_n = bytes_q + N'(popcount4(head_q.be));
    end
    // Head register mirrors the next FIFO head; bypass when the FIFO drains
    // to the beat being pushed this cycle.
    if (count_n != '0) head_n = (remain == '0) ? push_word : mem[rd_ptr_n];
    write_n = count_n != '0;

`ifdef PKT_DMA_TIMEOUT_EN
    // Watchdog: consecutive busy cycles with neither push nor pop.
    if ((state_q == S_WRITE || state_q == S_DRAIN) && !push && !pop) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_n  = S_ERROR;
        count_n  = '0;
        wr_ptr_n = '0;
        rd_ptr_n = '0;
        write_n  = 1'b0;
      end else begin
        to_cnt_n = to_cnt_q + TO_W'(1);
      end
    end
`endif

    ready_n = (state_n == S_WAIT_SOP) ||
              (state_n == S_WRITE && !eop_n && count_n < CNT_W'(FIFO_DEPTH)) ||
              (state_n == S_DRAIN && !eop_n);

    case (state_n)
      S_IDLE:  status_n = 2'b00;
      S_DONE:  status_n = 2'b10;
      S_ERROR: status_n = 2'b11;
      default: status_n = 2'b01;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      bytes_q     <= '0;
      words_q     <= '0;
      len_words_q <= '0;
      len_mask_q  <= '0;
      trunc_q     <= 1'b0;
      eop_q       <= 1'b0;
      head_q      <= '0;
      write_q     <= 1'b0;
      ready_q     <= 1'b0;
      status_q    <= 2'b00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
`ifdef PKT_DMA_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_n;
      addr_q      <= addr_n;
      bytes_q     <= bytes_n;
      words_q     <= words_n;
      len_words_q <= len_words_n;
      len_mask_q  <= len_mask_n;
      trunc_q     <= trunc_n;
      eop_q       <= eop_n;
      head_q      <= head_n;
      write_q     <= write_n;
      ready_q     <= ready_n;
      status_q    <= status_n;
      wr_ptr_q    <= wr_ptr_n;
      rd_ptr_q    <= rd_ptr_n;
      count_q     <= count_n;
`ifdef PKT_DMA_TIMEOUT_EN
      to_cnt_q    <= to_cnt_n;
`endif
    end
  end

  // FIFO storage; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_word;
  end

  assign st_ready       = ready_q;
  assign avm_address    = addr_q;
  assign avm_write      = write_q;
  assign avm_writedata  = head_q.data;
  assign avm_byteenable = head_q.be;
  assign state          = status_q;
  assign bytes_written  = bytes_q;

endmodule

// File: tb/tb_pkt_dma_writer.sv
// Directed testbench for pkt_dma_writer (default build).
module tb_pkt_dma_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] pkt_addr, pkt_len, st_data;
  logic        st_valid, st_ready, st_sop, st_eop;
  logic [1:0]  st_empty;
  logic [31:0] avm_address, avm_writedata;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [1:0]  state;
  logic [31:0] bytes_written;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [3:0]  log_be[$];

  logic        stall_mode = 1'b0;
  logic        stab_en    = 1'b0;
  logic        saw_bp     = 1'b0;
  int          wcnt       = 0;
  logic        prev_write = 1'b0;
  logic        prev_wait  = 1'b0;
  logic [67:0] prev_bus   = '0;

  pkt_dma_writer #(.N(32), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .pkt_addr(pkt_addr), .pkt_len(pkt_len),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready), .st_sop(st_sop),
    .st_eop(st_eop), .st_empty(st_empty), .avm_address(avm_address),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .state(state), .bytes_written(bytes_written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave model: optional 5-cycle stall per write, stall stability check, write log
  always @(negedge clk) begin
    if (!stall_mode) begin
      avm_waitrequest = 1'b0;
      wcnt = 0;
    end else if (avm_write) begin
      if (wcnt == 5) begin
        avm_waitrequest = 1'b0;
        wcnt = 0;
      end else begin
        avm_waitrequest = 1'b1;
        wcnt++;
      end
    end else begin
      avm_waitrequest = 1'b1;
    end
    if (stab_en && prev_write && prev_wait)
      chk("stall_hold", {11'd0, avm_write, avm_address, avm_writedata, avm_byteenable},
          {11'd0, 1'b1, prev_bus});
    if (avm_write && !avm_waitrequest) begin
      log_addr.push_back(avm_address);
      log_data.push_back(avm_writedata);
      log_be.push_back(avm_byteenable);
    end
    if (stall_mode && st_valid && !st_ready) saw_bp = 1'b1;
    prev_write = avm_write;
    prev_wait  = avm_waitrequest;
    prev_bus   = {avm_address, avm_writedata, avm_byteenable};
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_be.delete();
  endtask

  task automatic beat(input logic [31:0] d, input logic sop, input logic eop, input logic [1:0] emp);
    int  k;
    logic ok;
    st_data = d; st_sop = sop; st_eop = eop; st_empty = emp; st_valid = 1'b1;
    k = 0;
    ok = 1'b0;
    while (!ok && k < 200) begin
      @(negedge clk);
      ok = st_ready;
      @(posedge clk);
      #1;
      k++;
    end
    if (!ok) chk("beat_accept_timeout", 80'(ok), 80'd1);
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_empty = 2'd0;
  endtask

  task automatic send_pkt(input int n, input logic [31:0] dbase, input logic [1:0] last_emp);
    for (int i = 0; i < n; i++)
      beat(dbase + 32'(i), i == 0, i == n - 1, (i == n - 1) ? last_emp : 2'd0);
  endtask

  task automatic do_start(input logic [31:0] a, input logic [31:0] l);
    pkt_addr = a;
    pkt_len  = l;
    start    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [1:0] exp, input int budget);
    int k;
    k = 0;
    while (state !== exp && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 80'(state), 80'(exp));
  endtask

  task automatic check_log(input string tag, input int n, input logic [31:0] base,
                           input logic [31:0] dbase, input logic [3:0] last_be);
    chk($sformatf("%s nwrites", tag), 80'(log_addr.size()), 80'(n));
    for (int i = 0; i < n && i < log_addr.size(); i++) begin
      chk($sformatf("%s addr%0d", tag, i), 80'(log_addr[i]), 80'(base + 32'(4 * i)));
      chk($sformatf("%s data%0d", tag, i), 80'(log_data[i]), 80'(dbase + 32'(i)));
      chk($sformatf("%s be%0d", tag, i), 80'(log_be[i]), 80'((i == n - 1) ? last_be : 4'hF));
    end
  endtask

  task automatic finish_pkt(input string tag);
    start = 1'b0;
    wait_state({tag, " idle"}, 2'b00, 20);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; pkt_addr = '0; pkt_len = '0;
    st_data = '0; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_empty = 2'd0;
    avm_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst state", 80'(state), 80'd0);
    chk("rst avm_write", 80'(avm_write), 80'd0);
    chk("rst st_ready", 80'(st_ready), 80'd0);
    chk("rst bytes", 80'(bytes_written), 80'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Full 3-word packet, exact length
    clear_log();
    do_start(32'h1000, 32'd12);
    chk("t1 busy", 80'(state), 80'd1);
    send_pkt(3, 32'hA000_0000, 2'd0);
    wait_state("t1 done", 2'b10, 100);
    check_log("t1", 3, 32'h1000, 32'hA000_0000, 4'hF);
    chk("t1 bytes", 80'(bytes_written), 80'd12);
    finish_pkt("t1");

    // Length limit mid-packet: truncate, drain the rest, report error
    clear_log();
    do_start(32'h1000, 32'd6);
    chk("t2 bytes cleared", 80'(bytes_written), 80'd0);
    send_pkt(4, 32'hB000_0000, 2'd0);
    wait_state("t2 error", 2'b11, 100);
    check_log("t2", 2, 32'h1000, 32'hB000_0000, 4'h3);
    chk("t2 bytes", 80'(bytes_written), 80'd6);
    finish_pkt("t2");

    // Partial eop word
    clear_log();
    do_start(32'h1000, 32'd64);
    send_pkt(2, 32'hC000_0000, 2'd1);
    wait_state("t3 done", 2'b10, 100);
    check_log("t3", 2, 32'h1000, 32'hC000_0000, 4'h7);
    chk("t3 bytes", 80'(bytes_written), 80'd7);
    finish_pkt("t3");

    // Slave stalls 5 cycles per write; FIFO fills and back-pressures
    clear_log();
    stall_mode = 1'b1;
    stab_en    = 1'b1;
    saw_bp     = 1'b0;
    do_start(32'h2000, 32'd40);
    send_pkt(10, 32'hD000_0000, 2'd0);
    wait_state("t4 done", 2'b10, 500);
    check_log("t4", 10, 32'h2000, 32'hD000_0000, 4'hF);
    chk("t4 bytes", 80'(bytes_written), 80'd40);
    chk("t4 backpressure", 80'(saw_bp), 80'd1);
    stab_en    = 1'b0;
    stall_mode = 1'b0;
    finish_pkt("t4");

    // Beats before sop are discarded; held start does not retrigger
    clear_log();
    do_start(32'h3000, 32'd8);
    for (int i = 0; i < 3; i++) beat(32'hBAD0_0000 + 32'(i), 1'b0, 1'b0, 2'd0);
    send_pkt(2, 32'hE000_0000, 2'd0);
    wait_state("t5 done", 2'b10, 100);
    repeat (20) @(posedge clk);
    #1;
    chk("t5 held", 80'(state), 80'd2);
    check_log("t5", 2, 32'h3000, 32'hE000_0000, 4'hF);
    chk("t5 bytes", 80'(bytes_written), 80'd8);
    finish_pkt("t5");

    // Asynchronous reset while a write is pending
    clear_log();
    stall_mode = 1'b1;
    do_start(32'h4000, 32'd16);
    send_pkt(4, 32'hF000_0000, 2'd0);
    @(negedge clk);
    chk("t6 write pending", 80'(avm_write), 80'd1);
    #1;
    reset = 1'b0;
    start = 1'b0;
    #1;
    chk("t6 rst avm_write", 80'(avm_write), 80'd0);
    chk("t6 rst state", 80'(state), 80'd0);
    chk("t6 rst st_ready", 80'(st_ready), 80'd0);
    chk("t6 rst bytes", 80'(bytes_written), 80'd0);
    stall_mode = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    do_start(32'h5000, 32'd8);
    send_pkt(2, 32'h1234_0000, 2'd0);
    wait_state("t6 done", 2'b10, 100);
    check_log("t6", 2, 32'h5000, 32'h1234_0000, 4'hF);
    chk("t6 bytes", 80'(bytes_written), 80'd8);
    finish_pkt("t6");

    // Setup errors: misaligned address, zero length
    clear_log();
    do_start(32'h1002, 32'd4);
    chk("t7 misaligned", 80'(state), 80'd3);
    finish_pkt("t7a");
    do_start(32'h1000, 32'd0);
    chk("t7 zero len", 80'(state), 80'd3);
    finish_pkt("t7b");
    chk("t7 nwrites", 80'(log_addr.size()), 80'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
